half_adder: RTL and testbench
=============================

HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent half-adder lanes (legal 1..32).
REQ-002 Port: clk  input  1  rising-edge clock; all state updates on rising edge only.
REQ-003 Port: rst  input  1  reset, synchronous, active-high; sampled on rising clk edge.
REQ-004 Port: in_valid  input  1  operands on a/b are accepted this cycle.
REQ-005 Port: a  input  WIDTH  addend operand, one bit per lane.
REQ-006 Port: b  input  WIDTH  addend operand, one bit per lane.
REQ-007 Port: clear  input  1  synchronous clear of statistics counters.
REQ-008 Port: sum  output  WIDTH  registered per-lane sum bit.
REQ-009 Port: carry  output  WIDTH  registered per-lane carry bit.
REQ-010 Port: out_valid  output  1  sum/carry hold a result accepted on the previous edge.
REQ-011 Port: op_count  output  16  number of accepted operations, saturating.
REQ-012 Port: carry_count  output  16  number of accepted operations with any carry bit set, saturating.

Function
REQ-013 Per lane i: sum[i] SHALL equal a[i] XOR b[i]; carry[i] SHALL equal a[i] AND b[i].
REQ-014 The result SHALL be registered: on a rising edge with in_valid=1, sum/carry load the values for the a/b present at that edge. Latency is 1 cycle.
REQ-015 out_valid SHALL equal in_valid registered by one cycle. Back-to-back in_valid produces one result every cycle.
REQ-016 When in_valid=0 at an edge, sum and carry SHALL hold their previous values, and out_valid SHALL go 0.
REQ-017 op_count SHALL increment by 1 on every edge with in_valid=1. It holds at 16'hFFFF, with no wrap.
REQ-018 carry_count SHALL increment by 1 on every edge with in_valid=1 and (a AND b) nonzero. It holds at 16'hFFFF, with no wrap.
REQ-019 clear=1 at an edge SHALL set op_count and carry_count to 0. The sum/carry/out_valid datapath is unaffected.
REQ-020 clear=1 and in_valid=1 on the same edge: clear wins, so both counters become 0 and the operation is not counted. sum/carry still load the new result.
REQ-021 Outputs SHALL contain no combinational path from any input. No X SHALL propagate after reset when inputs are driven.

Reset
REQ-022 rst=1 at an edge SHALL set sum=0, carry=0, out_valid=0, op_count=0 and carry_count=0.
REQ-023 rst has priority over in_valid and clear. An operation presented on a reset edge SHALL be discarded and not counted.
REQ-024 Reset asserted mid-stream SHALL drop any result in flight: out_valid=0 on the cycle after the reset edge.
REQ-025 The first accepted operation after reset deasserts SHALL produce out_valid=1 one cycle later.

Verification
REQ-026 Truth table (WIDTH=1), in_valid=1 each cycle, pairs (a,b) = 00, 01, 10, 11:
- Expected (sum,carry) one cycle later: 00, 10, 10, 01.
- op_count SHALL reach 4 and carry_count 1.
REQ-027 Hold: apply (1,1) with in_valid=1, then change a/b to (0,1) with in_valid=0 for 3 cycles:
- sum=0 and carry=1 SHALL persist.
- out_valid SHALL be 1 for one cycle, then 0.
REQ-028 Reset mid-stream: stream 11, then assert rst together with ab=01 and in_valid=1:
- The next cycle SHALL show all outputs 0.
- Both counters SHALL be 0.
REQ-029 Saturation: 65540 accepted ops with a=b=1:
- op_count=16'hFFFF and carry_count=16'hFFFF, with no wrap.
- clear=1 SHALL then return both counters to 0.
REQ-030 Clear collision: clear=1 and in_valid=1 with ab=11 on the same edge:
- Counters SHALL be 0.
- sum=0 and carry=1 SHALL load.
REQ-031 Multi-lane WIDTH=4, a=4'b1100, b=4'b1010:
- Next cycle SHALL show sum=4'b0110 and carry=4'b1000.
- carry_count SHALL increment by 1.

Source files
------------

// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   WIDTH independent registered half-adder lanes with accepted-operation
//   statistics. Each lane produces sum = a ^ b and carry = a & b one cycle
//   after an accepted operation (in_valid=1). Results hold while no new
//   operation is accepted.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset
//   in_valid    in   1      a/b accepted on this edge
//   a, b        in   WIDTH  per-lane operands
//   clear       in   1      synchronous clear of the statistics counters
//   sum         out  WIDTH  registered per-lane sum
//   carry       out  WIDTH  registered per-lane carry
//   out_valid   out  1      sum/carry hold a result accepted on the previous edge
//   op_count    out  16     accepted operations, saturating at 16'hFFFF
//   carry_count out  16     accepted operations with any carry set, saturating
// ---------------------------------------------------------------------------
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clear,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid,
  output logic [15:0]      op_count,
  output logic [15:0]      carry_count
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  logic [WIDTH-1:0] sum_p1_q,   sum_p1_d;
  logic [WIDTH-1:0] carry_p1_q, carry_p1_d;
  logic             vld_p1_q,   vld_p1_d;
  logic [15:0]      op_cnt_q,   op_cnt_d;
  logic [15:0]      cy_cnt_q,   cy_cnt_d;
  logic             any_carry;

  // ---- stage p0 -> p1: lane arithmetic and counter next-state ----
  assign any_carry = |(a & b);

  always_comb begin
    sum_p1_d   = sum_p1_q;
    carry_p1_d = carry_p1_q;
    vld_p1_d   = in_valid;
    op_cnt_d   = op_cnt_q;
    cy_cnt_d   = cy_cnt_q;

    if (in_valid) begin
      sum_p1_d   = a ^ b;
      carry_p1_d = a & b;
    end

    // clear beats a simultaneous accept: the operation still produces a
    // result but is not counted.
    if (clear) begin
      op_cnt_d = 16'd0;
      cy_cnt_d = 16'd0;
    end else if (in_valid) begin
      op_cnt_d = sat_inc(op_cnt_q);
      if (any_carry) begin
        cy_cnt_d = sat_inc(cy_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p1_q   <= '0;
      carry_p1_q <= '0;
      vld_p1_q   <= 1'b0;
      op_cnt_q   <= 16'd0;
      cy_cnt_q   <= 16'd0;
    end else begin
      sum_p1_q   <= sum_p1_d;
      carry_p1_q <= carry_p1_d;
      vld_p1_q   <= vld_p1_d;
      op_cnt_q   <= op_cnt_d;
      cy_cnt_q   <= cy_cnt_d;
    end
  end

  // ---- stage p1: registered outputs ----
  assign sum         = sum_p1_q;
  assign carry       = carry_p1_q;
  assign out_valid   = vld_p1_q;
  assign op_count    = op_cnt_q;
  assign carry_count = cy_cnt_q;

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;

  logic        clk = 1'b0;
  logic        rst, clear;
  // WIDTH=1 instance
  logic        in_valid1, a1, b1;
  logic        sum1, carry1, ov1;
  logic [15:0] opc1, cc1;
  // WIDTH=4 instance
  logic        in_valid4;
  logic [3:0]  a4, b4, sum4, carry4;
  logic        ov4;
  logic [15:0] opc4, cc4;

  int n_assert = 0;
  int n_fail   = 0;

  // scoreboard / reference model for the WIDTH=1 instance
  logic [1:0] exp_q[$];   // {sum, carry}
  logic [1:0] m_hold;
  logic       m_ov;
  int         m_op, m_cc;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .a(a1), .b(b1), .clear(clear),
    .sum(sum1), .carry(carry1), .out_valid(ov1),
    .op_count(opc1), .carry_count(cc1)
  );

  half_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .a(a4), .b(b4), .clear(clear),
    .sum(sum4), .carry(carry4), .out_valid(ov4),
    .op_count(opc4), .carry_count(cc4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle on the WIDTH=1 instance: drive at negedge, update the
  // model, sample 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic iv, input logic ai, input logic bi,
                     input logic clr, input bit chk);
    logic [1:0] e;
    @(negedge clk);
    rst = r; in_valid1 = iv; a1 = ai; b1 = bi; clear = clr;
    if (r) begin
      exp_q.delete();
      m_hold = 2'b00; m_ov = 1'b0; m_op = 0; m_cc = 0;
    end else begin
      if (iv) exp_q.push_back({ai ^ bi, ai & bi});
      m_ov = iv;
      if (clr) begin
        m_op = 0; m_cc = 0;
      end else if (iv) begin
        if (m_op < 65535) m_op++;
        if ((ai & bi) && m_cc < 65535) m_cc++;
      end
    end
    @(posedge clk);
    #1;
    if (ov1) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        m_hold = e;
      end
    end
    if (chk) begin
      check("out_valid", {31'd0, ov1}, {31'd0, m_ov});
      check("sum",       {31'd0, sum1},   {31'd0, m_hold[1]});
      check("carry",     {31'd0, carry1}, {31'd0, m_hold[0]});
      check("op_count",    {16'd0, opc1}, m_op);
      check("carry_count", {16'd0, cc1},  m_cc);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    m_hold = 2'b00; m_ov = 1'b0; m_op = 0; m_cc = 0;

    // reset
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 0, 1);
    check("rst_ov4",  {31'd0, ov4}, 32'd0);
    check("rst_sum4", {28'd0, sum4}, 32'd0);
    check("rst_cnt4", {16'd0, opc4}, 32'd0);

    // multi-lane WIDTH=4
    in_valid4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
    cyc(0, 0, 0, 0, 0, 1);
    check("ml_sum",   {28'd0, sum4},   32'b0110);
    check("ml_carry", {28'd0, carry4}, 32'b1000);
    check("ml_ov",    {31'd0, ov4},    32'd1);
    check("ml_cc",    {16'd0, cc4},    32'd1);
    check("ml_op",    {16'd0, opc4},   32'd1);
    in_valid4 = 1'b0;
    a4 = 4'b0011; b4 = 4'b0101;
    cyc(0, 0, 0, 0, 0, 1);
    check("ml_hold",  {28'd0, sum4},   32'b0110);
    check("ml_ov0",   {31'd0, ov4},    32'd0);

    // truth table
    cyc(0, 1, 0, 0, 0, 1);
    check("tt00", {30'd0, sum1, carry1}, 32'b00);
    cyc(0, 1, 0, 1, 0, 1);
    check("tt01", {30'd0, sum1, carry1}, 32'b10);
    cyc(0, 1, 1, 0, 0, 1);
    check("tt10", {30'd0, sum1, carry1}, 32'b10);
    cyc(0, 1, 1, 1, 0, 1);
    check("tt11", {30'd0, sum1, carry1}, 32'b01);
    check("tt_op", {16'd0, opc1}, 32'd4);
    check("tt_cc", {16'd0, cc1},  32'd1);

    // hold
    cyc(0, 1, 1, 1, 0, 1);
    check("hold_ov1", {31'd0, ov1}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0, 1);
      check("hold_sc", {30'd0, sum1, carry1}, 32'b01);
      check("hold_ov", {31'd0, ov1}, 32'd0);
    end

    // reset mid-stream
    cyc(0, 1, 1, 1, 0, 1);
    cyc(1, 1, 0, 1, 0, 1);
    check("rm_out", {27'd0, sum1, carry1, ov1}, 32'd0);
    check("rm_cnt", {opc1, cc1}, 32'd0);

    // clear collision
    cyc(0, 1, 0, 1, 0, 1);
    cyc(0, 1, 1, 1, 1, 1);
    check("cc_cnt", {opc1, cc1}, 32'd0);
    check("cc_sc",  {30'd0, sum1, carry1}, 32'b01);

    // saturation
    for (int i = 0; i < 65540; i++) begin
      cyc(0, 1, 1, 1, 0, (i >= 65532));
    end
    check("sat_op", {16'd0, opc1}, 32'hFFFF);
    check("sat_cc", {16'd0, cc1},  32'hFFFF);
    cyc(0, 0, 0, 0, 1, 1);
    check("sat_clr", {opc1, cc1}, 32'd0);
    cyc(0, 1, 1, 0, 0, 1);
    check("post_clr_op", {16'd0, opc1}, 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
